// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter and sequencer in front of the unified single-port latency
// memory. The instruction-fetch port (IF, read-only) and the data-memory
// port (DM, read/write) share the memory one transaction at a time. For each
// granted transaction the block drives a single issue cycle on the memory
// (cs/wen/addr/data_in), counts out the fixed memory latency, captures
// data_out in the cycle it is valid, and returns a one-cycle ready pulse to
// the requester.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   if_req     IF read request, level, held until if_ready
//   if_addr    IF address, sampled at grant
//   if_ready   one-cycle pulse, if_rdata valid
//   if_rdata   IF read data, held until the next IF response
//   dm_req     DM request, level, held until dm_ready
//   dm_we      DM write enable (1 = write), sampled at grant
//   dm_addr    DM address, sampled at grant
//   dm_wdata   DM write data, sampled at grant
//   dm_ready   one-cycle pulse, read data valid or write committed
//   dm_rdata   DM read data, held until the next DM read response
//   mem_cs     memory chip select
//   mem_wen    memory write enable, active-low (0 = write)
//   mem_addr   memory address
//   mem_wdata  memory data_in
//   mem_rdata  memory data_out
//   busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ASIZE   = 16,
    parameter int DSIZE   = 16,
    parameter int LATENCY = 3,
    parameter int CNTW    = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req,
    input  logic [ASIZE-1:0] if_addr,
    output logic             if_ready,
    output logic [DSIZE-1:0] if_rdata,

    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [ASIZE-1:0] dm_addr,
    input  logic [DSIZE-1:0] dm_wdata,
    output logic             dm_ready,
    output logic [DSIZE-1:0] dm_rdata,

    output logic             mem_cs,
    output logic             mem_wen,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata,

    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // Counter load value: WAIT lasts LATENCY cycles, counting down to zero.
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNTW-1:0]  cnt;
    logic             last_grant;
    logic             grant_port;
    logic [ASIZE-1:0] lat_addr;
    logic             lat_we;
    logic [DSIZE-1:0] lat_wdata;
    logic [DSIZE-1:0] if_rdata_q;
    logic [DSIZE-1:0] dm_rdata_q;

    logic             any_req;
    logic             pick_dm;

    // Arbitration decision, only acted on in IDLE. DM wins when it is the
    // only requester, or on a tie when IF had the previous grant. Because
    // last_grant resets to IF, the first tie after reset goes to DM.
    always_comb begin
        any_req = if_req | dm_req;
        pick_dm = dm_req & (~if_req | (last_grant == PORT_IF));
    end

    // Next-state logic. ISSUE and RESP are single-cycle states; WAIT leaves
    // once the latency counter has reached zero, so cnt never underflows.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any transaction in flight; because the
    // ready pulses are decoded from RESP, no pulse can follow an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latency counter: loaded while issuing, counted down while waiting.
    // The value in WAIT tells how many more cycles until mem_rdata is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNTW'(1);
        end
    end

    // Grant capture. Everything the memory needs is latched on the grant
    // edge, so the requester is free to change its address and data lines
    // afterwards without disturbing the transaction. IF is read-only, so its
    // write enable and write data are forced to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_IF;
            grant_port <= PORT_IF;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
        end else if (state == IDLE && any_req) begin
            if (pick_dm) begin
                last_grant <= PORT_DM;
                grant_port <= PORT_DM;
                lat_addr   <= dm_addr;
                lat_we     <= dm_we;
                lat_wdata  <= dm_wdata;
            end else begin
                last_grant <= PORT_IF;
                grant_port <= PORT_IF;
                lat_addr   <= if_addr;
                lat_we     <= 1'b0;
                lat_wdata  <= '0;
            end
        end
    end

    // Read data capture on the last WAIT cycle, which is exactly the cycle
    // the memory presents valid data_out. Writes leave the port's read data
    // untouched so the requester keeps its previous read result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (state == WAIT && cnt == '0 && !lat_we) begin
            if (grant_port == PORT_DM) begin
                dm_rdata_q <= mem_rdata;
            end else begin
                if_rdata_q <= mem_rdata;
            end
        end
    end

    // Output decode from state and registers only. The memory commits a
    // write whenever its pipeline sees wen low, so wen is held high in every
    // state except ISSUE, and the address/data buses are parked at zero
    // outside the issue cycle.
    always_comb begin
        mem_cs    = (state == ISSUE);
        mem_wen   = ~((state == ISSUE) & lat_we);
        mem_addr  = (state == ISSUE) ? lat_addr  : '0;
        mem_wdata = (state == ISSUE) ? lat_wdata : '0;
        if_ready  = (state == RESP) & (grant_port == PORT_IF);
        dm_ready  = (state == RESP) & (grant_port == PORT_DM);
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small behavioural latency memory is
// attached to the memory side: an issue is carried through a LATENCY-deep
// pipeline, reads present data_out in the last stage (junk otherwise) and
// writes commit when the last stage holds wen low. Each scenario task drives
// stimulus and checks cycle-numbered expectations inline.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ASIZE   = 16;
    localparam int DSIZE   = 16;
    localparam int LATENCY = 3;
    localparam int CNTW    = 2;

    logic             clk;
    logic             rst;
    logic             if_req;
    logic [ASIZE-1:0] if_addr;
    logic             if_ready;
    logic [DSIZE-1:0] if_rdata;
    logic             dm_req;
    logic             dm_we;
    logic [ASIZE-1:0] dm_addr;
    logic [DSIZE-1:0] dm_wdata;
    logic             dm_ready;
    logic [DSIZE-1:0] dm_rdata;
    logic             mem_cs;
    logic             mem_wen;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata;
    logic             busy;

    int checks;
    int failures;

    mem_arbiter #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .LATENCY(LATENCY), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural latency memory, 256 words, synchronous reset of the pipe.
    logic [DSIZE-1:0] mem_array [0:255];
    logic             p_cs   [LATENCY];
    logic             p_wen  [LATENCY];
    logic [ASIZE-1:0] p_addr [LATENCY];
    logic [DSIZE-1:0] p_data [LATENCY];
    int               write_count;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                p_cs[i]   <= 1'b0;
                p_wen[i]  <= 1'b1;
                p_addr[i] <= '0;
                p_data[i] <= '0;
            end
        end else begin
            p_cs[0]   <= mem_cs;
            p_wen[0]  <= mem_wen;
            p_addr[0] <= mem_addr;
            p_data[0] <= mem_wdata;
            for (int i = 1; i < LATENCY; i++) begin
                p_cs[i]   <= p_cs[i-1];
                p_wen[i]  <= p_wen[i-1];
                p_addr[i] <= p_addr[i-1];
                p_data[i] <= p_data[i-1];
            end
            if (!p_wen[LATENCY-1]) begin
                mem_array[p_addr[LATENCY-1][7:0]] <= p_data[LATENCY-1];
                write_count <= write_count + 1;
            end
        end
    end

    assign mem_rdata = (p_cs[LATENCY-1] && p_wen[LATENCY-1]) ?
                       mem_array[p_addr[LATENCY-1][7:0]] : 16'hDEAD;

    // Reset values while rst is held, then still idle after release.
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=%b", {mem_cs, mem_wen, if_ready, dm_ready, busy}, 5'b01000);
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_cs, mem_wen, busy} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL reset_release got=%b exp=010", {mem_cs, mem_wen, busy});
        end
        @(posedge clk); #1;
    endtask

    // Single IF read: cs only in cycle 1, ready only in cycle 5.
    task automatic test_if_read(input logic [15:0] addr, input logic [15:0] exp_data);
        logic [4:0] ev;
        if_req  = 1'b1;
        if_addr = addr;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            ev = {c == 1, 1'b1, c == 5, 1'b0, c >= 1 && c <= 5};
            checks++;
            if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== ev) begin
                failures++;
                $display("[TB] FAIL if_read_ctrl c=%0d got=%b exp=%b", c, {mem_cs, mem_wen, if_ready, dm_ready, busy}, ev);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== addr) begin
                    failures++;
                    $display("[TB] FAIL if_read_addr got=%h exp=%h", mem_addr, addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (if_rdata !== exp_data) begin
                    failures++;
                    $display("[TB] FAIL if_read_data got=%h exp=%h", if_rdata, exp_data);
                end
            end
            @(posedge clk); #1;
            if (c == 5) if_req = 1'b0;
        end
        checks++;
        if (if_rdata !== exp_data) begin
            failures++;
            $display("[TB] FAIL if_read_hold got=%h exp=%h", if_rdata, exp_data);
        end
    endtask

    // DM write of 0x1234 to 0x0020 followed by a read back.
    task automatic test_dm_write_read();
        logic [4:0] ev;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0020;
        dm_wdata = 16'h1234;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            ev = {c == 1, c != 1, 1'b0, c == 5, c >= 1 && c <= 5};
            checks++;
            if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== ev) begin
                failures++;
                $display("[TB] FAIL dm_write_ctrl c=%0d got=%b exp=%b", c, {mem_cs, mem_wen, if_ready, dm_ready, busy}, ev);
            end
            if (c == 1) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {16'h0020, 16'h1234}) begin
                    failures++;
                    $display("[TB] FAIL dm_write_bus got=%h exp=%h", {mem_addr, mem_wdata}, {16'h0020, 16'h1234});
                end
            end
            if (c == 5) begin
                checks++;
                if (dm_rdata !== 16'h0000) begin
                    failures++;
                    $display("[TB] FAIL dm_write_rdata got=%h exp=0000", dm_rdata);
                end
            end
            @(posedge clk); #1;
            if (c == 5) dm_req = 1'b0;
        end
        checks++;
        if (mem_array[8'h20] !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL dm_write_commit got=%h exp=1234", mem_array[8'h20]);
        end
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_wdata = 16'hFFFF;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            ev = {c == 1, 1'b1, 1'b0, c == 5, c >= 1 && c <= 5};
            checks++;
            if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== ev) begin
                failures++;
                $display("[TB] FAIL dm_read_ctrl c=%0d got=%b exp=%b", c, {mem_cs, mem_wen, if_ready, dm_ready, busy}, ev);
            end
            if (c == 5) begin
                checks++;
                if (dm_rdata !== 16'h1234) begin
                    failures++;
                    $display("[TB] FAIL dm_read_data got=%h exp=1234", dm_rdata);
                end
            end
            @(posedge clk); #1;
            if (c == 5) dm_req = 1'b0;
        end
    endtask

    // 50 idle cycles: bus quiet every cycle, no writes reach the memory.
    task automatic test_idle();
        int wc0;
        int bad;
        wc0 = write_count;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_cs, mem_wen, busy} !== 3'b010) begin
                failures++;
                bad++;
                if (bad <= 3) $display("[TB] FAIL idle_bus c=%0d got=%b exp=010", c, {mem_cs, mem_wen, busy});
            end
            @(posedge clk); #1;
        end
        checks++;
        if (write_count !== wc0 || mem_array[8'h10] !== 16'hBEEF || mem_array[8'h20] !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL idle_mem writes=%0d exp=%0d m10=%h m20=%h", write_count, wc0, mem_array[8'h10], mem_array[8'h20]);
        end
    endtask

    // Both ports request right after reset and stay high: DM, IF, DM, IF.
    task automatic test_simultaneous();
        logic [4:0]  ev;
        logic [15:0] ea;
        int          ph;
        int          k;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 16'h0010;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 16'h0020;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ph = c % 6;
            k  = c / 6;
            ev = {ph == 1, 1'b1, ph == 5 && k % 2 == 1, ph == 5 && k % 2 == 0, ph != 0};
            checks++;
            if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== ev) begin
                failures++;
                $display("[TB] FAIL rr_ctrl c=%0d got=%b exp=%b", c, {mem_cs, mem_wen, if_ready, dm_ready, busy}, ev);
            end
            if (ph == 1) begin
                ea = (k % 2 == 0) ? 16'h0020 : 16'h0010;
                checks++;
                if (mem_addr !== ea) begin
                    failures++;
                    $display("[TB] FAIL rr_addr c=%0d got=%h exp=%h", c, mem_addr, ea);
                end
            end
            if (c == 5) begin
                checks++;
                if ({dm_rdata, if_rdata} !== {16'h1234, 16'h0000}) begin
                    failures++;
                    $display("[TB] FAIL rr_first_data got=%h exp=%h", {dm_rdata, if_rdata}, {16'h1234, 16'h0000});
                end
            end
            if (c == 11) begin
                checks++;
                if (if_rdata !== 16'hBEEF) begin
                    failures++;
                    $display("[TB] FAIL rr_second_data got=%h exp=beef", if_rdata);
                end
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reset during a DM write's WAIT, then a fresh IF read.
    task automatic test_reset_mid_wait();
        logic [4:0] ev;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0040;
        dm_wdata = 16'h5555;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            ev = {c == 1, c != 1, 1'b0, 1'b0, c >= 1};
            checks++;
            if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== ev) begin
                failures++;
                $display("[TB] FAIL abort_pre c=%0d got=%b exp=%b", c, {mem_cs, mem_wen, if_ready, dm_ready, busy}, ev);
            end
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        #2;
        rst    = 1'b1;
        dm_req = 1'b0;
        #1;
        checks++;
        if ({mem_cs, mem_wen, if_ready, dm_ready, busy} !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL abort_ctrl got=%b exp=01000", {mem_cs, mem_wen, if_ready, dm_ready, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL abort_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        test_if_read(16'h0030, 16'hCAFE);
    endtask

    // Address changes after the grant edge must not affect the access.
    task automatic test_late_change();
        if_req  = 1'b1;
        if_addr = 16'h0010;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (mem_addr !== 16'h0010) begin
                    failures++;
                    $display("[TB] FAIL late_addr got=%h exp=0010", mem_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if ({if_ready, if_rdata} !== {1'b1, 16'hBEEF}) begin
                    failures++;
                    $display("[TB] FAIL late_data got=%h exp=%h", {if_ready, if_rdata}, {1'b1, 16'hBEEF});
                end
            end
            @(posedge clk); #1;
            if (c == 1) if_addr = 16'h0030;
            if (c == 5) if_req = 1'b0;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        write_count = 0;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int i = 0; i < 256; i++) mem_array[i] = 16'h0000;
        mem_array[8'h10] = 16'hBEEF;
        mem_array[8'h30] = 16'hCAFE;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_if_read(16'h0010, 16'hBEEF);
        test_dm_write_read();
        test_idle();
        test_simultaneous();
        test_reset_mid_wait();
        test_late_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
